// File: rtl/jk_pkg.sv
// Shared encodings for the JK excitation controller: command ops, FSM states,
// and the JK excitation function that maps (present, target) bits to {J,K}.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_COUNT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_APPLY   = 2'b10,
        ST_CHECK   = 2'b11
    } state_e;

    // Don't-care entries resolve to 0, so J=K=1 is never produced.
    function automatic logic [1:0] jk_excite(input logic q_bit, input logic t_bit);
        logic [1:0] jk;
        case ({q_bit, t_bit})
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of W edge-triggered JK flip-flops with asynchronous active-high reset.
// J=K=0 holds, J=1 sets, K=1 resets, J=K=1 toggles.
module jk_ff_bank
    import jk_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         c,
    input  logic         rst,
    input  logic [W-1:0] j,
    input  logic [W-1:0] k,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_excitation_ctrl.sv
// Command-driven JK excitation controller: turns a requested next bank state into
// per-bit J/K drive, applies it for one cycle, and verifies the result by readback.
module jk_excitation_ctrl
    import jk_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         c,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] j_q, j_d;
    logic [W-1:0] k_q, k_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         mis_q, mis_d;
    logic [W-1:0] bank_q;
    logic         mismatch;

    jk_ff_bank #(.W(W)) u_bank (
        .c   (c),
        .rst (rst),
        .j   (j_q),
        .k   (k_q),
        .q   (bank_q)
    );

    assign mismatch = (bank_q != tgt_q);

    always_comb begin
        // NOTE: every *_d is defaulted before the case, so no branch can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = op_e'(cmd_op);
                    data_d  = cmd_data;
                    mis_d   = 1'b0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                state_d = ST_APPLY;
                case (op_q)
                    OP_LOAD:   tgt_d = data_q;
                    OP_CLEAR:  tgt_d = '0;
                    OP_TOGGLE: tgt_d = bank_q ^ data_q;
                    OP_COUNT: begin
                        cnt_d = data_q;
                        // A zero step count verifies the current value without touching it.
                        if (data_q == '0) begin
                            tgt_d   = bank_q;
                            state_d = ST_CHECK;
                        end else begin
                            tgt_d = bank_q + W'(1);
                        end
                    end
                    default: tgt_d = tgt_q;
                endcase
            end
            ST_APPLY: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (op_q == OP_COUNT && cnt_q > W'(1)) begin
                    cnt_d   = cnt_q - W'(1);
                    tgt_d   = bank_q + W'(1);
                    mis_d   = mis_q | mismatch;
                    state_d = ST_APPLY;
                end else begin
                    done_d  = 1'b1;
                    err_d   = mis_q | mismatch;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_APPLY) begin
            for (int i = 0; i < W; i++) begin
                {j_d[i], k_d[i]} = jk_excite(bank_q[i], tgt_d[i]);
            end
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign j         = j_q;
    assign k         = k_q;
    assign q         = bank_q;

endmodule

// File: tb/tb_jk_excitation_ctrl.sv
// Self-checking bench for jk_excitation_ctrl: a per-command trace model feeds a
// cycle-tagged expectation queue, plus literal checks at hand-computed points.
module tb_jk_excitation_ctrl;
    import jk_pkg::*;

    localparam int W = 4;

    logic         c = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         cmd_ready;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         err;

    jk_excitation_ctrl #(.W(W)) dut (
        .c         (c),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j         (j),
        .k         (k),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 c = ~c;

    typedef struct {
        int           cyc;
        logic         busy;
        logic         ready;
        logic         done;
        logic         err;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] q;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc      = 0;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] model_q  = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic void push(input int at, input logic b, input logic r, input logic d,
                                 input logic e, input logic [W-1:0] jj, input logic [W-1:0] kk,
                                 input logic [W-1:0] qq);
        exp_t x;
        x.cyc = at; x.busy = b; x.ready = r; x.done = d; x.err = e;
        x.j = jj; x.k = kk; x.q = qq;
        exp_q.push_back(x);
    endfunction

    // Expected trace of one command accepted on the edge that ends cycle at0.
    function automatic int model_cmd(input int at0, input op_e op, input logic [W-1:0] data,
                                     input logic exp_err);
        logic [W-1:0] tl[$];
        logic [W-1:0] qp;
        int           t_at;
        case (op)
            OP_LOAD:   tl.push_back(data);
            OP_CLEAR:  tl.push_back({W{1'b0}});
            OP_TOGGLE: tl.push_back(model_q ^ data);
            default: begin
                for (int s = 1; s <= int'(data); s++) tl.push_back(model_q + W'(s));
            end
        endcase
        t_at = at0 + 1;
        push(t_at, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, model_q);
        t_at++;
        qp = model_q;
        foreach (tl[i]) begin
            push(t_at, 1'b1, 1'b0, 1'b0, 1'b0, tl[i] & ~qp, ~tl[i] & qp, qp);
            t_at++;
            push(t_at, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, tl[i]);
            t_at++;
            qp = tl[i];
        end
        if (tl.size() == 0) begin
            push(t_at, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, qp);
            t_at++;
        end
        push(t_at, 1'b0, 1'b1, 1'b1, exp_err, '0, '0, qp);
        model_q = qp;
        return t_at;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge c);
    endtask

    task automatic idle(input int n);
        int base;
        base = cyc;
        for (int i = 1; i <= n; i++) push(base + i, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, model_q);
        wait_cyc(base + n);
    endtask

    // Called at a negedge; the command is accepted on the next rising edge.
    task automatic start_cmd(input op_e op, input logic [W-1:0] data, input logic exp_err,
                             output int done_cyc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        done_cyc  = model_cmd(cyc, op, data, exp_err);
        @(negedge c);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input op_e op, input logic [W-1:0] data);
        int d;
        start_cmd(op, data, 1'b0, d);
        wait_cyc(d);
    endtask

    // Compare process: every cycle that has a model record is checked field by field.
    initial begin
        exp_t e;
        forever begin
            @(posedge c);
            #2;
            cyc++;
            check("jk_overlap", j & k, '0);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    n_checks++;
                    $display("FAIL stale_record: record for cycle %0d unchecked at cycle %0d", e.cyc, cyc);
                end else begin
                    check("busy", W'(busy), W'(e.busy));
                    check("cmd_ready", W'(cmd_ready), W'(e.ready));
                    check("done", W'(done), W'(e.done));
                    check("err", W'(err), W'(e.err));
                    check("j", j, e.j);
                    check("k", k, e.k);
                    check("q", q, e.q);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, d1, d2;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_q", q, 4'b0000);
        check("rst_j", j, 4'b0000);
        check("rst_k", k, 4'b0000);
        check("rst_ready", W'(cmd_ready), 4'd1);
        check("rst_busy", W'(busy), 4'd0);
        check("rst_done", W'(done), 4'd0);
        check("rst_err", W'(err), 4'd0);
        @(negedge c);
        rst = 1'b0;
        idle(2);

        // LOAD 1010 from 0000
        c0 = cyc;
        start_cmd(OP_LOAD, 4'b1010, 1'b0, d1);
        wait_cyc(c0 + 2);
        check("load_apply_j", j, 4'b1010);
        check("load_apply_k", k, 4'b0000);
        wait_cyc(c0 + 4);
        check("load_q", q, 4'b1010);
        check("load_done", W'(done), 4'd1);
        check("load_err", W'(err), 4'd0);

        // TOGGLE 0110 from 1010 -> 1100
        c0 = cyc;
        start_cmd(OP_TOGGLE, 4'b0110, 1'b0, d1);
        wait_cyc(c0 + 2);
        check("toggle_apply_j", j, 4'b0100);
        check("toggle_apply_k", k, 4'b0010);
        wait_cyc(c0 + 4);
        check("toggle_q", q, 4'b1100);
        check("toggle_done", W'(done), 4'd1);
        check("toggle_err", W'(err), 4'd0);

        // COUNT 3 from 1110 wraps through 0000
        run_cmd(OP_LOAD, 4'b1110);
        c0 = cyc;
        start_cmd(OP_COUNT, 4'd3, 1'b0, d1);
        wait_cyc(c0 + 3);
        check("count_step1", q, 4'b1111);
        wait_cyc(c0 + 5);
        check("count_wrap", q, 4'b0000);
        wait_cyc(c0 + 7);
        check("count_step3", q, 4'b0001);
        wait_cyc(c0 + 8);
        check("count_done", W'(done), 4'd1);

        // COUNT 0 with cmd_valid held while busy; the follow-on LOAD waits for IDLE
        run_cmd(OP_LOAD, 4'b0101);
        c0 = cyc;
        cmd_valid = 1'b1;
        cmd_op    = OP_COUNT;
        cmd_data  = '0;
        d1 = model_cmd(c0, OP_COUNT, '0, 1'b0);
        @(negedge c);
        cmd_op   = OP_LOAD;
        cmd_data = 4'b0011;
        d2 = model_cmd(d1, OP_LOAD, 4'b0011, 1'b0);
        wait_cyc(c0 + 2);
        check("hold_not_ready", W'(cmd_ready), 4'd0);
        wait_cyc(c0 + 3);
        check("count0_done", W'(done), 4'd1);
        check("count0_q", q, 4'b0101);
        @(negedge c);
        cmd_valid = 1'b0;
        check("hold_accept_busy", W'(busy), 4'd1);
        wait_cyc(d2);
        check("hold_load_q", q, 4'b0011);

        // CLEAR from 1111
        run_cmd(OP_LOAD, 4'b1111);
        c0 = cyc;
        start_cmd(OP_CLEAR, '0, 1'b0, d1);
        wait_cyc(c0 + 2);
        check("clear_apply_j", j, 4'b0000);
        check("clear_apply_k", k, 4'b1111);
        wait_cyc(c0 + 4);
        check("clear_q", q, 4'b0000);
        check("clear_err", W'(err), 4'd0);

        // CLEAR with the readback overridden during CHECK -> err with done
        run_cmd(OP_LOAD, 4'b1111);
        c0 = cyc;
        start_cmd(OP_CLEAR, '0, 1'b1, d1);
        wait_cyc(c0 + 3);
        force dut.bank_q = 4'b0001;
        @(posedge c);
        #1;
        release dut.bank_q;
        @(negedge c);
        check("forced_done", W'(done), 4'd1);
        check("forced_err", W'(err), 4'd1);

        // Reset in the middle of COUNT 5 from 0010, after two steps
        run_cmd(OP_LOAD, 4'b0010);
        c0 = cyc;
        start_cmd(OP_COUNT, 4'd5, 1'b0, d1);
        wait_cyc(c0 + 5);
        check("midcount_q", q, 4'b0100);
        rst = 1'b1;
        exp_q.delete();
        model_q = '0;
        #1;
        check("abort_q", q, 4'b0000);
        check("abort_busy", W'(busy), 4'd0);
        check("abort_ready", W'(cmd_ready), 4'd1);
        check("abort_done", W'(done), 4'd0);
        @(posedge c);
        #3;
        check("abort_hold_done", W'(done), 4'd0);
        check("abort_hold_q", q, 4'b0000);
        @(negedge c);
        rst = 1'b0;
        idle(3);
        check("post_reset_q", q, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
